// File: rtl/multadd_unit.sv
// ============================================================================
// multadd_unit : prodsum = a*b + c*d (unsigned) with a runtime-selectable
//                1-register or 3-register timing path.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module multadd_unit #(
   parameter int DATA_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [DATA_W-1:0]   c,
   input  logic [DATA_W-1:0]   d,
   input  logic                pipeline,
   output logic [2*DATA_W:0]   prodsum,
   output logic                prodout
);

   localparam int PROD_W = 2 * DATA_W;

   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [DATA_W-1:0] r_c;
   logic [DATA_W-1:0] r_d;
   logic              r_v1;
   logic [PROD_W-1:0] r_p_ab;
   logic [PROD_W-1:0] r_p_cd;
   logic              r_v2;
   logic              r_last_mode;

   logic [PROD_W-1:0] w_in_ab;
   logic [PROD_W-1:0] w_in_cd;
   logic [PROD_W:0]   w_direct_sum;
   logic [PROD_W-1:0] w_s1_ab;
   logic [PROD_W-1:0] w_s1_cd;
   logic [PROD_W:0]   w_pipe_sum;

   assign w_in_ab      = PROD_W'(a) * PROD_W'(b);
   assign w_in_cd      = PROD_W'(c) * PROD_W'(d);
   assign w_direct_sum = {1'b0, w_in_ab} + {1'b0, w_in_cd};

   assign w_s1_ab      = PROD_W'(r_a) * PROD_W'(r_b);
   assign w_s1_cd      = PROD_W'(r_c) * PROD_W'(r_d);
   assign w_pipe_sum   = {1'b0, r_p_ab} + {1'b0, r_p_cd};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a         <= '0;
         r_b         <= '0;
         r_c         <= '0;
         r_d         <= '0;
         r_v1        <= 1'b0;
         r_p_ab      <= '0;
         r_p_cd      <= '0;
         r_v2        <= 1'b0;
         r_last_mode <= 1'b0;
         prodsum     <= '0;
         prodout     <= 1'b0;
      end else begin
         r_last_mode <= pipeline;
         r_a         <= a;
         r_b         <= b;
         r_c         <= c;
         r_d         <= d;
         r_p_ab      <= w_s1_ab;
         r_p_cd      <= w_s1_cd;
         if (pipeline) begin
            // An S1 entry only advances if the previous edge was also pipelined.
            r_v1 <= 1'b1;
            r_v2 <= r_v1 & r_last_mode;
            if (r_v2) begin
               prodsum <= w_pipe_sum;
               prodout <= 1'b1;
            end else begin
               prodout <= 1'b0;
            end
         end else begin
            // Leaving pipelined mode discards everything in flight.
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            prodsum <= w_direct_sum;
            prodout <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_multadd_unit.sv
// ============================================================================
// tb_multadd_unit : directed and randomised self-checking bench for multadd_unit
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_multadd_unit;

   localparam int DATA_W = 8;
   localparam int SUM_W  = 2 * DATA_W + 1;

   logic              clk;
   logic              rst;
   logic [DATA_W-1:0] a, b, c, d;
   logic              pipeline;
   logic [SUM_W-1:0]  prodsum;
   logic              prodout;

   int n_checks;
   int n_fail;

   multadd_unit #(.DATA_W(DATA_W)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .pipeline (pipeline),
      .prodsum  (prodsum),
      .prodout  (prodout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one operation, then return 1 time unit after the edge that samples it.
   task automatic step(input logic pl, input int va, input int vb, input int vc, input int vd);
      pipeline = pl;
      a = DATA_W'(va);
      b = DATA_W'(vb);
      c = DATA_W'(vc);
      d = DATA_W'(vd);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pipeline = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (prodsum !== '0) begin
         $display("FAIL reset_prodsum actual=%0d required=0", prodsum); n_fail++;
      end
      n_checks++;
      if (prodout !== 1'b0) begin
         $display("FAIL reset_prodout actual=%b required=0", prodout); n_fail++;
      end
   endtask

   task automatic test_mode0();
      do_reset();
      step(1'b0, 3, 4, 5, 6);
      n_checks++;
      if (prodsum !== SUM_W'(42) || prodout !== 1'b1) begin
         $display("FAIL mode0_basic actual=%0d/%b required=42/1", prodsum, prodout); n_fail++;
      end
   endtask

   task automatic test_mode1_stream();
      int exp_sum[5];
      logic exp_out[5];
      exp_out = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_sum = '{0, 0, 14, 200, 130050};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         case (i)
            0:       step(1'b1, 1, 2, 3, 4);
            1:       step(1'b1, 10, 10, 10, 10);
            2:       step(1'b1, 255, 255, 255, 255);
            default: step(1'b1, 0, 0, 0, 0);
         endcase
         n_checks++;
         if (prodout !== exp_out[i]) begin
            $display("FAIL mode1_stream_prodout edge=%0d actual=%b required=%b", i + 1, prodout, exp_out[i]); n_fail++;
         end
         if (exp_out[i]) begin
            n_checks++;
            if (prodsum !== SUM_W'(exp_sum[i])) begin
               $display("FAIL mode1_stream_prodsum edge=%0d actual=%0d required=%0d", i + 1, prodsum, exp_sum[i]); n_fail++;
            end
         end
      end
   endtask

   task automatic test_switch_1to0();
      do_reset();
      step(1'b1, 1, 2, 3, 4);
      step(1'b1, 5, 5, 5, 5);
      step(1'b1, 6, 6, 6, 6);
      n_checks++;
      if (prodsum !== SUM_W'(14) || prodout !== 1'b1) begin
         $display("FAIL sw10_edge3 actual=%0d/%b required=14/1", prodsum, prodout); n_fail++;
      end
      step(1'b0, 2, 2, 2, 2);
      n_checks++;
      if (prodsum !== SUM_W'(8) || prodout !== 1'b1) begin
         $display("FAIL sw10_edge4 actual=%0d/%b required=8/1", prodsum, prodout); n_fail++;
      end
      step(1'b1, 0, 0, 0, 0);
      n_checks++;
      if (prodsum !== SUM_W'(8) || prodout !== 1'b0) begin
         $display("FAIL sw10_edge5 actual=%0d/%b required=8/0", prodsum, prodout); n_fail++;
      end
      step(1'b1, 0, 0, 0, 0);
      n_checks++;
      if (prodsum !== SUM_W'(8) || prodout !== 1'b0) begin
         $display("FAIL sw10_edge6 actual=%0d/%b required=8/0", prodsum, prodout); n_fail++;
      end
   endtask

   task automatic test_switch_0to1();
      do_reset();
      step(1'b0, 1, 1, 1, 1);
      n_checks++;
      if (prodsum !== SUM_W'(2) || prodout !== 1'b1) begin
         $display("FAIL sw01_edge1 actual=%0d/%b required=2/1", prodsum, prodout); n_fail++;
      end
      step(1'b1, 2, 3, 4, 5);
      n_checks++;
      if (prodsum !== SUM_W'(2) || prodout !== 1'b0) begin
         $display("FAIL sw01_edge2 actual=%0d/%b required=2/0", prodsum, prodout); n_fail++;
      end
      step(1'b1, 0, 0, 0, 0);
      n_checks++;
      if (prodsum !== SUM_W'(2) || prodout !== 1'b0) begin
         $display("FAIL sw01_edge3 actual=%0d/%b required=2/0", prodsum, prodout); n_fail++;
      end
      step(1'b1, 0, 0, 0, 0);
      n_checks++;
      if (prodsum !== SUM_W'(26) || prodout !== 1'b1) begin
         $display("FAIL sw01_edge4 actual=%0d/%b required=26/1", prodsum, prodout); n_fail++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b1, 1, 2, 3, 4);
      step(1'b1, 5, 5, 5, 5);
      step(1'b1, 6, 6, 6, 6);
      n_checks++;
      if (prodsum !== SUM_W'(14) || prodout !== 1'b1) begin
         $display("FAIL arst_before actual=%0d/%b required=14/1", prodsum, prodout); n_fail++;
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (prodsum !== '0 || prodout !== 1'b0) begin
         $display("FAIL arst_immediate actual=%0d/%b required=0/0", prodsum, prodout); n_fail++;
      end
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 9, 9, 9, 9);
         n_checks++;
         if (prodout !== (i == 2)) begin
            $display("FAIL arst_restart_prodout edge=%0d actual=%b required=%b", i + 1, prodout, (i == 2)); n_fail++;
         end
      end
      n_checks++;
      if (prodsum !== SUM_W'(162)) begin
         $display("FAIL arst_restart_prodsum actual=%0d required=162", prodsum); n_fail++;
      end
   endtask

   // Reference: pipelined ops queue with a due edge; a mode-0 edge flushes the queue.
   task automatic test_random();
      int             due_q[$];
      int             val_q[$];
      int             exp_sum;
      logic           exp_out;
      int             va, vb, vc, vd, val;
      logic           pl;
      do_reset();
      exp_sum = 0;
      for (int n = 0; n < 300; n++) begin
         pl = ($urandom_range(0, 3) != 0);
         if (n % 50 == 0) begin
            va = 0; vb = 0; vc = 0; vd = 0;
         end else if (n % 50 == 25) begin
            va = 255; vb = 255; vc = 255; vd = 255;
         end else begin
            va = $urandom_range(0, 255); vb = $urandom_range(0, 255);
            vc = $urandom_range(0, 255); vd = $urandom_range(0, 255);
         end
         val = va * vb + vc * vd;
         if (!pl) begin
            due_q.delete();
            val_q.delete();
            exp_out = 1'b1;
            exp_sum = val;
         end else begin
            due_q.push_back(n + 2);
            val_q.push_back(val);
            if (due_q[0] == n) begin
               void'(due_q.pop_front());
               exp_sum = val_q.pop_front();
               exp_out = 1'b1;
            end else begin
               exp_out = 1'b0;
            end
         end
         step(pl, va, vb, vc, vd);
         n_checks++;
         if (prodout !== exp_out) begin
            $display("FAIL random_prodout n=%0d actual=%b required=%b", n, prodout, exp_out); n_fail++;
         end
         n_checks++;
         if (prodsum !== SUM_W'(exp_sum)) begin
            $display("FAIL random_prodsum n=%0d actual=%0d required=%0d", n, prodsum, exp_sum); n_fail++;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      pipeline = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      test_reset();
      test_mode0();
      test_mode1_stream();
      test_switch_1to0();
      test_switch_0to1();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
